// File: rtl/vend_port_arbiter.sv
// Round-robin arbiter sharing one vending core between NPORTS coin panels.
// Define VEND_ARB_TIMEOUT_EN to abort/release purchases left idle in LOCK for TIMEOUT cycles.
module vend_port_arbiter #(
  parameter int NPORTS  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORTS-1:0]     coin_valid,
  input  logic [2*NPORTS-1:0]   coin,
  output logic [NPORTS-1:0]     coin_ready,
  output logic [1:0]            core_in,
  output logic                  core_rst,
  input  logic                  core_out,
  input  logic [1:0]            core_change,
  output logic [NPORTS-1:0]     vend_out,
  output logic [2*NPORTS-1:0]   vend_change,
  output logic [NPORTS-1:0]     refund,
  output logic [3:0]            refund_val,
  output logic                  busy,
  output logic [1:0]            owner
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCK  = 3'd1,
    ST_FEED  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  localparam logic [2:0] CREDIT_MAX  = 3'd4;
  localparam logic [2:0] CREDIT_FAIL = 3'd3;
  localparam logic [1:0] RR_INIT     = 2'(NPORTS - 1);

  state_t              state_r, state_nxt_s;
  logic [1:0]          owner_r, owner_nxt_s;
  logic [1:0]          rr_r, rr_nxt_s;
  logic [2:0]          credit_r, credit_nxt_s;
  logic [1:0]          coin_r, coin_nxt_s;
  logic                grant_found_s;
  logic [1:0]          grant_idx_s;
  logic                owner_valid_s;
  logic [1:0]          owner_coin_s;
  logic [NPORTS-1:0]   coin_ready_s;

  logic [1:0]          core_in_r;
  logic [NPORTS-1:0]   vend_out_r;
  logic [2*NPORTS-1:0] vend_change_r;
  logic [NPORTS-1:0]   refund_r;
  logic [3:0]          refund_val_r;
  logic                abort_r;
  logic                busy_r;
  logic [1:0]          owner_out_r;

`ifdef VEND_ARB_TIMEOUT_EN
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
  logic [7:0]          idle_cnt_r, idle_cnt_nxt_s;
`endif

  function automatic logic [2:0] coin_steps(input logic [1:0] code);
    case (code)
      2'd1:    coin_steps = 3'd1;
      2'd2:    coin_steps = 3'd2;
      default: coin_steps = 3'd0;
    endcase
  endfunction

  function automatic logic coin_legal(input logic [1:0] code);
    coin_legal = (code == 2'd1) || (code == 2'd2);
  endfunction

  // Credit saturates at CREDIT_MAX instead of wrapping.
  function automatic logic [2:0] credit_add(input logic [2:0] credit, input logic [1:0] code);
    logic [3:0] sum;
    sum = {1'b0, credit} + {1'b0, coin_steps(code)};
    credit_add = (sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum[2:0];
  endfunction

  function automatic logic [1:0] rr_cand(input logic [1:0] rr, input int step);
    logic [2:0] c;
    c = {1'b0, rr} + 3'(step);
    c = (c >= 3'(NPORTS)) ? (c - 3'(NPORTS)) : c;
    rr_cand = c[1:0];
  endfunction

  function automatic logic [NPORTS-1:0] port_sel(input logic [1:0] idx);
    for (int p = 0; p < NPORTS; p++) begin
      port_sel[p] = (idx == 2'(p));
    end
  endfunction

  function automatic logic [2*NPORTS-1:0] port_code(input logic [1:0] idx, input logic [1:0] code);
    for (int p = 0; p < NPORTS; p++) begin
      port_code[2*p +: 2] = (idx == 2'(p)) ? code : 2'd0;
    end
  endfunction

  // Current owner's request and coin code.
  always_comb begin
    owner_valid_s = 1'b0;
    owner_coin_s  = 2'd0;
    for (int p = 0; p < NPORTS; p++) begin
      owner_valid_s = (owner_r == 2'(p)) ? coin_valid[p]   : owner_valid_s;
      owner_coin_s  = (owner_r == 2'(p)) ? coin[2*p +: 2]  : owner_coin_s;
    end
  end

  // First requesting port after the RR pointer, wrapping around.
  always_comb begin
    logic hit;
    hit           = 1'b0;
    grant_found_s = 1'b0;
    grant_idx_s   = rr_r;
    for (int k = 1; k <= NPORTS; k++) begin
      for (int p = 0; p < NPORTS; p++) begin
        hit           = !grant_found_s && coin_valid[p] && (rr_cand(rr_r, k) == 2'(p));
        grant_idx_s   = hit ? 2'(p) : grant_idx_s;
        grant_found_s = grant_found_s | hit;
      end
    end
  end

  // Next-state, datapath updates and the combinational coin handshake.
  always_comb begin
    state_nxt_s  = state_r;
    owner_nxt_s  = owner_r;
    rr_nxt_s     = rr_r;
    credit_nxt_s = credit_r;
    coin_nxt_s   = coin_r;
    coin_ready_s = {NPORTS{1'b0}};
`ifdef VEND_ARB_TIMEOUT_EN
    idle_cnt_nxt_s = 8'd0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          owner_nxt_s = grant_idx_s;
          rr_nxt_s    = grant_idx_s;
          state_nxt_s = ST_LOCK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (owner_valid_s) begin
          coin_ready_s = port_sel(owner_r);
          // Illegal codes are consumed so the panel cannot wedge the port.
          if (coin_legal(owner_coin_s)) begin
            coin_nxt_s   = owner_coin_s;
            credit_nxt_s = credit_add(credit_r, owner_coin_s);
            state_nxt_s  = ST_FEED;
          end else begin
            state_nxt_s  = ST_LOCK;
          end
        end else begin
`ifdef VEND_ARB_TIMEOUT_EN
          if (idle_cnt_r == IDLE_LAST) begin
            state_nxt_s = (credit_r != 3'd0) ? ST_ABORT : ST_IDLE;
          end else begin
            idle_cnt_nxt_s = idle_cnt_r + 8'd1;
            state_nxt_s    = ST_LOCK;
          end
`else
          state_nxt_s = ST_LOCK;
`endif
        end
      end
      ST_FEED: begin
        state_nxt_s = ST_CHECK;
      end
      ST_CHECK: begin
        if (core_out) begin
          state_nxt_s = ST_DONE;
        end else if (credit_r >= CREDIT_FAIL) begin
          state_nxt_s = ST_ABORT;
        end else begin
          state_nxt_s = ST_LOCK;
        end
      end
      ST_DONE: begin
        credit_nxt_s = 3'd0;
        state_nxt_s  = ST_IDLE;
      end
      ST_ABORT: begin
        credit_nxt_s = 3'd0;
        state_nxt_s  = ST_IDLE;
      end
      default: begin
        credit_nxt_s = 3'd0;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // FSM state and purchase datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      owner_r  <= 2'd0;
      rr_r     <= RR_INIT;
      credit_r <= 3'd0;
      coin_r   <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      rr_r     <= rr_nxt_s;
      credit_r <= credit_nxt_s;
      coin_r   <= coin_nxt_s;
    end
  end

`ifdef VEND_ARB_TIMEOUT_EN
  // Idle-cycle counter for the owned LOCK state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= 8'd0;
    end else begin
      idle_cnt_r <= idle_cnt_nxt_s;
    end
  end
`endif

  // Outputs registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in_r     <= 2'd0;
      vend_out_r    <= {NPORTS{1'b0}};
      vend_change_r <= {(2*NPORTS){1'b0}};
      refund_r      <= {NPORTS{1'b0}};
      refund_val_r  <= 4'd0;
      abort_r       <= 1'b0;
      busy_r        <= 1'b0;
      owner_out_r   <= 2'd0;
    end else begin
      core_in_r     <= (state_nxt_s == ST_FEED)  ? coin_nxt_s : 2'd0;
      vend_out_r    <= (state_nxt_s == ST_DONE)  ? port_sel(owner_nxt_s) : {NPORTS{1'b0}};
      vend_change_r <= (state_nxt_s == ST_DONE)  ? port_code(owner_nxt_s, core_change)
                                                 : {(2*NPORTS){1'b0}};
      refund_r      <= (state_nxt_s == ST_ABORT) ? port_sel(owner_nxt_s) : {NPORTS{1'b0}};
      refund_val_r  <= (state_nxt_s == ST_ABORT) ? {1'b0, credit_nxt_s} : 4'd0;
      abort_r       <= (state_nxt_s == ST_ABORT);
      busy_r        <= (state_nxt_s != ST_IDLE);
      owner_out_r   <= (state_nxt_s != ST_IDLE) ? owner_nxt_s : 2'd0;
    end
  end

  assign coin_ready  = coin_ready_s;
  assign core_in     = core_in_r;
  assign core_rst    = ~rst_n | abort_r;
  assign vend_out    = vend_out_r;
  assign vend_change = vend_change_r;
  assign refund      = refund_r;
  assign refund_val  = refund_val_r;
  assign busy        = busy_r;
  assign owner       = owner_out_r;

endmodule

// File: tb/tb_vend_port_arbiter.sv
// Bench for vend_port_arbiter: panel coin queues, a registered core model and a
// cycle-calendar purchase model checked against the DUT on every cycle.
module tb_vend_port_arbiter;

  localparam int NP = 2;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     coin_valid;
  logic [2*NP-1:0]   coin;
  logic [NP-1:0]     coin_ready;
  logic [1:0]        core_in;
  logic              core_rst;
  logic              core_out;
  logic [1:0]        core_change;
  logic [NP-1:0]     vend_out;
  logic [2*NP-1:0]   vend_change;
  logic [NP-1:0]     refund;
  logic [3:0]        refund_val;
  logic              busy;
  logic [1:0]        owner;

  vend_port_arbiter #(.NPORTS(NP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin(coin),
    .coin_ready(coin_ready), .core_in(core_in), .core_rst(core_rst),
    .core_out(core_out), .core_change(core_change), .vend_out(vend_out),
    .vend_change(vend_change), .refund(refund), .refund_val(refund_val),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n = 0;

  logic [1:0] pq [NP][$];
  int  core_total;
  bit  core_pend;
  int  core_pend_chg;
  bit  core_dead = 1'b0;

  bit  m_active;
  int  m_owner, m_rr, m_credit, m_accept_from, m_feed_cyc, m_feed_code, m_decide_cyc;
  int  m_vend_cyc, m_vend_chg, m_abort_cyc, m_abort_val, m_idle;

  int  grant_log[$];
  int  dut_grants[$];
  int  ready_cnt[NP], vend_cnt[NP], last_vchg[NP], refund_cnt[NP];
  int  last_rval, rst_pulses;
  bit  prev_busy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_owner = 0; m_rr = NP - 1; m_credit = 0; m_idle = 0;
    m_accept_from = -1; m_feed_cyc = -1; m_feed_code = 0; m_decide_cyc = -1;
    m_vend_cyc = -1; m_vend_chg = 0; m_abort_cyc = -1; m_abort_val = 0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); dut_grants.delete();
    for (int p = 0; p < NP; p++) begin
      ready_cnt[p] = 0; vend_cnt[p] = 0; last_vchg[p] = -1; refund_cnt[p] = 0;
    end
    last_rval = -1; rst_pulses = 0;
  endtask

  function automatic bit pending();
    pending = 1'b0;
    for (int p = 0; p < NP; p++) if (pq[p].size() > 0) pending = 1'b1;
  endfunction

  // Compare the DUT against the model for the current cycle, then advance everything.
  task automatic compare_cycle();
    logic [NP-1:0]   e_ready, e_vend, e_ref;
    logic [2*NP-1:0] e_vchg;
    int e_rval, code, c;
    bit end_now, found;
    e_ready = '0; e_vend = '0; e_ref = '0; e_vchg = '0; e_rval = 0;
    if (m_active && m_accept_from >= 0 && n >= m_accept_from && coin_valid[m_owner])
      e_ready[m_owner] = 1'b1;
    if (n == m_vend_cyc) begin
      e_vend[m_owner] = 1'b1; e_vchg[2*m_owner +: 2] = 2'(m_vend_chg);
    end
    if (n == m_abort_cyc) begin
      e_ref[m_owner] = 1'b1; e_rval = m_abort_val;
    end
    chk("coin_ready", coin_ready, e_ready);
    chk("core_in", core_in, (n == m_feed_cyc) ? m_feed_code : 0);
    chk("vend_out", vend_out, e_vend);
    chk("vend_change", vend_change, e_vchg);
    chk("refund", refund, e_ref);
    chk("refund_val", refund_val, e_rval);
    chk("core_rst", core_rst, (n == m_abort_cyc) ? 1 : 0);
    chk("busy", busy, m_active);
    chk("owner", owner, m_active ? m_owner : 0);

    for (int p = 0; p < NP; p++) begin
      if (coin_ready[p]) begin ready_cnt[p]++; if (pq[p].size() > 0) void'(pq[p].pop_front()); end
      if (vend_out[p]) begin vend_cnt[p]++; last_vchg[p] = vend_change[2*p +: 2]; end
      if (refund[p]) begin refund_cnt[p]++; last_rval = refund_val; end
    end
    if (core_rst) rst_pulses++;
    if (busy && !prev_busy) dut_grants.push_back(owner);
    prev_busy = busy;

    if (core_rst) begin
      core_total = 0; core_pend = 1'b0;
    end else if (core_in != 2'd0) begin
      core_total += core_in;
      if (!core_dead && core_total >= 3) begin
        core_pend = 1'b1; core_pend_chg = core_total - 3; core_total = 0;
      end else core_pend = 1'b0;
    end else core_pend = 1'b0;

    end_now = 1'b0;
    if (!m_active) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        c = (m_rr + k) % NP;
        if (!found && coin_valid[c]) begin found = 1'b1; m_owner = c; end
      end
      if (found) begin
        m_rr = m_owner; m_active = 1'b1; m_accept_from = n + 1; m_idle = 0;
        grant_log.push_back(m_owner);
      end
    end else begin
      if (e_ready[m_owner]) begin
        m_idle = 0;
        code = coin[2*m_owner +: 2];
        if (code == 1 || code == 2) begin
          m_credit = (m_credit + code > 4) ? 4 : m_credit + code;
          m_feed_cyc = n + 1; m_feed_code = code; m_decide_cyc = n + 2; m_accept_from = -1;
        end
      end else if (m_accept_from >= 0 && n >= m_accept_from) begin
`ifdef VEND_ARB_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          m_accept_from = -1;
          if (m_credit > 0) begin m_abort_cyc = n + 1; m_abort_val = m_credit; end
          else end_now = 1'b1;
        end
`endif
      end
      if (n == m_decide_cyc) begin
        if (core_out) begin m_vend_cyc = n + 1; m_vend_chg = core_change; end
        else if (m_credit >= 3) begin m_abort_cyc = n + 1; m_abort_val = m_credit; end
        else begin m_accept_from = n + 1; m_idle = 0; end
      end
      if (n == m_vend_cyc || n == m_abort_cyc) end_now = 1'b1;
      if (end_now) begin
        m_active = 1'b0; m_credit = 0; m_accept_from = -1; m_idle = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) begin
      coin_valid[p]    = (pq[p].size() > 0);
      coin[2*p +: 2]   = (pq[p].size() > 0) ? pq[p][0] : 2'd0;
    end
    core_out    = core_pend;
    core_change = core_pend ? 2'(core_pend_chg) : 2'd0;
    @(negedge clk);
    compare_cycle();
    n++;
  endtask

  task automatic run(input int budget);
    int k;
    k = 0;
    step(); k++;
    while ((m_active || pending()) && k < budget) begin step(); k++; end
    if (m_active || pending()) chk("run_bound", m_active, 0);
    step(); step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; coin_valid = '0; coin = '0; core_out = 1'b0; core_change = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_vend_out", vend_out, 0);
    chk("rst_refund", refund, 0);
    chk("rst_coin_ready", coin_ready, 0);
    rst_n = 1'b1;
    model_reset();
    core_total = 0; core_pend = 1'b0; core_pend_chg = 0; prev_busy = 1'b0;
    for (int p = 0; p < NP; p++) pq[p].delete();
    n = 0;
    clear_logs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single purchase, port 0, 5+5+5.
    pq[0] = '{2'd1, 2'd1, 2'd1};
    run(60);
    chk("single_ready_cnt", ready_cnt[0], 3);
    chk("single_vend_cnt", vend_cnt[0], 1);
    chk("single_change", last_vchg[0], 0);
    chk("single_grant", dut_grants.size() > 0 ? dut_grants[0] : -1, 0);

    // Overpay, port 1, 10+10.
    clear_logs();
    pq[1] = '{2'd2, 2'd2};
    run(60);
    chk("overpay_vend_cnt", vend_cnt[1], 1);
    chk("overpay_change", last_vchg[1], 1);
    chk("overpay_model_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);

    // Illegal codes 3 and 0 mid-purchase are consumed and ignored.
    clear_logs();
    pq[0] = '{2'd1, 2'd3, 2'd0, 2'd2};
    run(60);
    chk("illegal_ready_cnt", ready_cnt[0], 4);
    chk("illegal_vend_cnt", vend_cnt[0], 1);
    chk("illegal_change", last_vchg[0], 0);

    // Dead core: 20 units reach the core with no vend, full refund.
    clear_logs();
    core_dead = 1'b1;
    pq[1] = '{2'd2, 2'd2};
    run(60);
    core_dead = 1'b0;
    chk("dead_refund_cnt", refund_cnt[1], 1);
    chk("dead_refund_val", last_rval, 4);
    chk("dead_rst_pulses", rst_pulses, 1);
    chk("dead_vend_cnt", vend_cnt[1], 0);

`ifdef VEND_ARB_TIMEOUT_EN
    // Port 0 inserts 10 units then goes quiet.
    clear_logs();
    pq[0] = '{2'd2};
    run(80);
    chk("timeout_refund_cnt", refund_cnt[0], 1);
    chk("timeout_refund_val", last_rval, 2);
    chk("timeout_rst_pulses", rst_pulses, 1);
    chk("timeout_busy", busy, 0);
`else
    // Without the timeout the owner keeps the core indefinitely.
    clear_logs();
    pq[0] = '{2'd1};
    repeat (40) step();
    chk("hold_busy", busy, 1);
    chk("hold_owner", owner, 0);
    pq[0].push_back(2'd2);
    run(60);
    chk("hold_vend_cnt", vend_cnt[0], 1);
    chk("hold_change", last_vchg[0], 0);
`endif

    // Reset asserted mid-FEED.
    do_reset();
    pq[0] = '{2'd1};
    step(); step();
    @(posedge clk); #2;
    chk("feed_core_in", core_in, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_core_rst", core_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_core_in", core_in, 0);
    chk("midrst_owner", owner, 0);
    do_reset();

    // Contention from reset: both ports buy 5+10 twice.
    pq[0] = '{2'd1, 2'd2, 2'd2, 2'd1};
    pq[1] = '{2'd1, 2'd2, 2'd2, 2'd1};
    run(200);
    chk("cont_grants", dut_grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant_order", (i < dut_grants.size()) ? dut_grants[i] : -1, i % 2);
      chk("cont_model_order", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
    end
    chk("cont_vend0", vend_cnt[0], 2);
    chk("cont_vend1", vend_cnt[1], 2);
    chk("cont_change1", last_vchg[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
